// File: rtl/spi_slave_if.sv
// SPI pin bundle between a mode-0 master and the spi_slave responder.
// The master modport drives chip select, clock and data out; the slave
// modport returns data and its output enable for top-level tri-stating.
interface spi_slave_if;
    logic cs;       // active-low chip select
    logic sck;      // SPI clock, idle low
    logic mosi;     // master out, slave in
    logic miso;     // master in, slave out
    logic miso_oe;  // miso drive enable

    modport master (
        output cs,
        output sck,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  cs,
        input  sck,
        input  mosi,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI responder with oversampled pins.
// Receives SIZE bits MSB-first on mosi and returns SIZE bits MSB-first on miso.
// A frame that ends with a bit count other than SIZE reports frame_err
// instead of updating rx_bytes.
module spi_slave #(
    parameter int SIZE  = 40,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [SIZE-1:0] tx_bytes,
    output logic [SIZE-1:0] rx_bytes,
    output logic            rx_valid,
    output logic            frame_err,
    output logic            busy,
    spi_slave_if.slave      spi
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

    // Pin synchronizers: s1/s2 resolve metastability, s3 is edge history.
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    logic cs_fall, cs_rise, sck_rise, sck_fall;

    logic [0:0]       state_q, state_d;
    logic [SIZE-1:0]  tx_sr_q, tx_sr_d;
    logic [SIZE-1:0]  rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             overrun_q, overrun_d;
    logic [SIZE-1:0]  rx_bytes_q, rx_bytes_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             miso_oe_q, miso_oe_d;

    // Two-stage synchronizers plus one history stage per pin; cs idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_s3_q  <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            cs_s1_q   <= spi.cs;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            sck_s1_q  <= spi.sck;
            sck_s2_q  <= sck_s1_q;
            sck_s3_q  <= sck_s2_q;
            mosi_s1_q <= spi.mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // Edge strobes from the synchronized level versus its history.
    always_comb begin
        cs_fall  = ~cs_s2_q &  cs_s3_q;
        cs_rise  =  cs_s2_q & ~cs_s3_q;
        sck_rise =  sck_s2_q & ~sck_s3_q;
        sck_fall = ~sck_s2_q &  sck_s3_q;
    end

    // Frame state machine: a cs rise closes the frame and swallows any
    // coincident sck edge, so the frame-close branch is checked first.
    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        bit_cnt_d   = bit_cnt_q;
        overrun_d   = overrun_q;
        rx_bytes_d  = rx_bytes_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = busy_q;
        miso_oe_d   = miso_oe_q;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    tx_sr_d   = tx_bytes;
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    overrun_d = 1'b0;
                    busy_d    = 1'b1;
                    miso_oe_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    if (bit_cnt_q == SIZE_C && !overrun_q) begin
                        rx_bytes_d = rx_sr_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    if (sck_rise) begin
                        if (bit_cnt_q < SIZE_C) begin
                            rx_sr_d   = {rx_sr_q[SIZE-2:0], mosi_s2_q};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        tx_sr_d = {tx_sr_q[SIZE-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            rx_bytes_q  <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            overrun_q   <= overrun_d;
            rx_bytes_q  <= rx_bytes_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    // miso presents the shifter MSB only while a frame is active.
    always_comb begin
        spi.miso    = (state_q == ST_ACTIVE) & tx_sr_q[SIZE-1];
        spi.miso_oe = miso_oe_q;
        rx_bytes    = rx_bytes_q;
        rx_valid    = rx_valid_q;
        frame_err   = frame_err_q;
        busy        = busy_q;
    end

endmodule
